cp0_exc: RTL

CP0_EXC -- requirements
Module: cp0_exc

---
 rtl/cp0_exc_pkg.sv | 21 ++
 rtl/cp0_exc.sv | 86 ++++++++
 2 files changed

// File: rtl/cp0_exc_pkg.sv
// Shared CP0 constants: register numbers, exception codes, fixed values.
package cp0_exc_pkg;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam logic [31:0] HANDLER_PC = 32'h0000_4180;
  localparam logic [31:0] PRID_VAL   = 32'h4D49_5053;
  localparam logic [31:0] SR_RESET   = 32'h0000_FC01;

endpackage

// File: rtl/cp0_exc.sv
// CP0 exception/interrupt block: SR, Cause, EPC, PRId plus exception entry.
module cp0_exc
  import cp0_exc_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [5:0]  hw_int,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic        eret,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        take_exc,
  output logic [31:0] handler_pc
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  code_q;
  logic [29:0] epc_hi;

  logic        int_pend;
  logic [29:0] epc_next_hi;

  assign int_pend    = (|(hw_int & im)) & ie & ~exl;
  assign take_exc    = int_pend | (exc_valid & ~exl);
  // EPC bits 1:0 are always zero, so only the word address is stored.
  assign epc_next_hi = bd_m ? (pc_m[31:2] - 30'd1) : pc_m[31:2];
  assign epc         = {epc_hi, 2'b00};
  assign handler_pc  = HANDLER_PC;

  // Register update: exception entry beats mtc0/eret; eret clears EXL after mtc0.
  always_ff @(posedge clk) begin
    if (reset) begin
      im     <= SR_RESET[15:10];
      exl    <= SR_RESET[1];
      ie     <= SR_RESET[0];
      bd     <= 1'b0;
      ip     <= '0;
      code_q <= '0;
      epc_hi <= '0;
    end else begin
      ip <= hw_int;
      if (take_exc) begin
        exl    <= 1'b1;
        code_q <= int_pend ? EXC_INT : exc_code;
        bd     <= bd_m;
        epc_hi <= epc_next_hi;
      end else begin
        if (we && addr == REG_SR) begin
          im  <= wdata[15:10];
          exl <= wdata[1];
          ie  <= wdata[0];
        end
        if (we && addr == REG_EPC) begin
          epc_hi <= wdata[31:2];
        end
        // Later non-blocking assignment makes eret override an SR write to EXL.
        if (eret) begin
          exl <= 1'b0;
        end
      end
    end
  end

  // mfc0 read mux from stored state; unimplemented numbers read zero.
  always_comb begin
    rdata = '0;
    case (addr)
      REG_SR:    rdata = {16'h0000, im, 8'h00, exl, ie};
      REG_CAUSE: rdata = {bd, 15'h0000, ip, 3'b000, code_q, 2'b00};
      REG_EPC:   rdata = {epc_hi, 2'b00};
      REG_PRID:  rdata = PRID_VAL;
      default:   rdata = '0;
    endcase
  end

endmodule
